imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of instruction-memory words, with a maximum legal word_count of DEPTH.
REQ-002 SHALL have parameter START_PC, default 0, meaning the value driven on z4 as the first fetch address after a load.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle load request.
REQ-006 SHALL have port word_count, input, 9 bits, the number of words to load, sampled when start is accepted.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, 32) and in_ready (output, 1), forming the program-word stream handshake.
REQ-008 SHALL have ports instruction_reset (output, 1), write_signal (output, 1), write_address (output, 32) and instruction_write (output, 32), forming the instruction-memory write port.
REQ-009 SHALL have port cpu_reset, output, 1 bit, the reset driven to the fetch stage and the IR2/PC2 registers.
REQ-010 SHALL have ports z4 (output, 32), select_pc (output, 2), select_ir2 (output, 2) and select_pc2 (output, 1), the fetch-stage mux controls.
REQ-011 SHALL have ports busy (output, 1), done (output, 1) and error (output, 1), the status flags.

Function
REQ-012 SHALL implement states IDLE, CLEAR, LOAD, DRAIN and RUN; all outputs SHALL be driven from registers or decoded from state only, with no combinational path from inputs.
REQ-013 In IDLE, start=1 with 1<=word_count<=DEPTH SHALL capture word_count, clear the index to 0 and error, and move to CLEAR.
REQ-014 In IDLE, start=1 with word_count=0 or word_count>DEPTH SHALL set error=1 (sticky until the next accepted start or reset) and remain in IDLE.
REQ-015 CLEAR SHALL last exactly 1 cycle with instruction_reset=1, then move to LOAD; instruction_reset SHALL be 0 in all other states.
REQ-016 In LOAD, in_ready SHALL be 1; a beat is accepted on a rising edge with in_valid=1 and in_ready=1, and back-to-back beats SHALL be accepted every cycle.
REQ-017 An accepted beat SHALL register write_signal=1, write_address=index (zero-extended) and instruction_write=in_data for the following cycle, then increment the index.
REQ-018 write_signal SHALL be 0 in any cycle not immediately following an accept.
REQ-019 Acceptance of beat number word_count SHALL move LOAD to DRAIN; DRAIN SHALL last 1 cycle, covering the final memory write, with in_ready=0, then move to RUN.
REQ-020 in_ready SHALL be 0 outside LOAD, and in_valid SHALL be ignored there.
REQ-021 In every state except RUN: cpu_reset=1, select_pc=0, select_ir2=1 (nop) and select_pc2=0.
REQ-022 In RUN: cpu_reset=0, select_pc=1, select_ir2=0, select_pc2=0 and done=1.
REQ-023 z4 SHALL equal START_PC at all times.
REQ-024 busy SHALL be 1 in CLEAR, LOAD and DRAIN, and 0 otherwise; done SHALL be 0 outside RUN.
REQ-025 In RUN, start=1 with a legal word_count SHALL reload: go to CLEAR, reassert cpu_reset and clear done in the next cycle; with an illegal count it SHALL set error and stay in RUN.
REQ-026 start SHALL be ignored in CLEAR, LOAD and DRAIN.
REQ-027 The index SHALL never exceed DEPTH-1; write_address SHALL never wrap.

Reset
REQ-028 reset=1 SHALL immediately, asynchronously, force IDLE with index=0, count=0, cpu_reset=1, instruction_reset=0, write_signal=0, write_address=0, instruction_write=0, in_ready=0, busy=0, done=0, error=0, select_pc=0, select_ir2=1, select_pc2=0.
REQ-029 reset asserted during LOAD SHALL abort the load with no further write_signal pulses; a new start is required after deassertion.

Verification
REQ-030 Basic load: start with word_count=4, data 10,11,12,13 streamed back-to-back -> instruction_reset pulse of 1 cycle; write_signal pulses at addresses 0..3 with data 10..13; RUN entered 1 cycle after the last write; cpu_reset falls; select_pc=1.
REQ-031 Stalled stream: word_count=3 with in_valid gapped (1,0,0,1,0,1) -> exactly 3 writes, at addresses 0,1,2, in order; busy=1 throughout.
REQ-032 Illegal counts: start with word_count=0, then with 257 -> error=1, state stays IDLE, no instruction_reset or write_signal; a following legal start clears error.
REQ-033 Full depth: word_count=256 -> last write at address 255, no wrap, done=1.
REQ-034 Mid-load reset: reset asserted after 2 of 5 beats -> outputs take reset values in the same cycle; no further writes; cpu_reset stays 1.
REQ-035 Reload: start with word_count=2 while in RUN -> cpu_reset=1 and done=0 in the next cycle; CLEAR, then 2 writes, then RUN again.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program into instruction memory, then releases the fetch stage.
// Holds the CPU in reset with nops selected while loading; RUN hands control back to the PC.
module imem_loader #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] START_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  word_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        instruction_reset,
  output logic        write_signal,
  output logic [31:0] write_address,
  output logic [31:0] instruction_write,
  output logic        cpu_reset,
  output logic [31:0] z4,
  output logic [1:0]  select_pc,
  output logic [1:0]  select_ir2,
  output logic        select_pc2,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, RUN} state_e;

  state_e        state_q, state_d;
  logic [8:0]    count_q, count_d;
  logic [IW-1:0] index_q, index_d;
  logic          error_q, error_d;
  logic          wr_q, wr_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic count_ok;
  logic last_beat;

  assign count_ok  = (word_count != 9'd0) && (32'(word_count) <= DEPTH);
  // The final beat leaves the index parked at count-1 so it never reaches DEPTH.
  assign last_beat = ((9'(index_q) + 9'd1) == count_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      error_q <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      error_q <= error_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    error_d = error_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          if (count_ok) begin
            count_d = word_count;
            index_d = '0;
            error_d = 1'b0;
            state_d = CLEAR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      CLEAR: state_d = LOAD;
      LOAD: begin
        if (in_valid) begin
          wr_d    = 1'b1;
          waddr_d = 32'(index_q);
          wdata_d = in_data;
          if (last_beat) begin
            state_d = DRAIN;
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
      DRAIN:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready          = (state_q == LOAD);
  assign instruction_reset = (state_q == CLEAR);
  assign busy              = (state_q == CLEAR) || (state_q == LOAD) || (state_q == DRAIN);
  assign done              = (state_q == RUN);
  assign cpu_reset         = (state_q != RUN);
  assign select_pc         = (state_q == RUN) ? 2'd1 : 2'd0;
  assign select_ir2        = (state_q == RUN) ? 2'd0 : 2'd1;
  assign select_pc2        = 1'b0;
  assign z4                = START_PC;
  assign write_signal      = wr_q;
  assign write_address     = waddr_q;
  assign instruction_write = wdata_q;
  assign error             = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam logic [31:0] PC0 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        instruction_reset;
  logic        write_signal;
  logic [31:0] write_address;
  logic [31:0] instruction_write;
  logic        cpu_reset;
  logic [31:0] z4;
  logic [1:0]  select_pc;
  logic [1:0]  select_ir2;
  logic        select_pc2;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  imem_loader #(.DEPTH(256), .START_PC(PC0)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .instruction_reset(instruction_reset), .write_signal(write_signal),
    .write_address(write_address), .instruction_write(instruction_write),
    .cpu_reset(cpu_reset), .z4(z4), .select_pc(select_pc), .select_ir2(select_ir2),
    .select_pc2(select_pc2), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic chk_reset_vals(input string t);
    chk1({t, "_cpu_reset"}, cpu_reset, 1'b1);
    chk1({t, "_ir"}, instruction_reset, 1'b0);
    chk1({t, "_ws"}, write_signal, 1'b0);
    chk({t, "_waddr"}, write_address, 32'd0);
    chk({t, "_wdata"}, instruction_write, 32'd0);
    chk1({t, "_in_ready"}, in_ready, 1'b0);
    chk1({t, "_busy"}, busy, 1'b0);
    chk1({t, "_done"}, done, 1'b0);
    chk1({t, "_error"}, error, 1'b0);
    chk({t, "_sel_pc"}, 32'(select_pc), 32'd0);
    chk({t, "_sel_ir2"}, 32'(select_ir2), 32'd1);
    chk1({t, "_sel_pc2"}, select_pc2, 1'b0);
    chk({t, "_z4"}, z4, PC0);
  endtask

  initial begin
    int nws;
    logic [5:0] pat;

    reset = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
    #2;
    chk_reset_vals("por");
    tick;
    reset = 1'b0;

    // basic load of four words
    start = 1'b1; word_count = 9'd4;
    tick;
    start = 1'b0;
    chk1("basic_clear_ir", instruction_reset, 1'b1);
    chk1("basic_clear_busy", busy, 1'b1);
    chk1("basic_clear_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_data = 32'd10;
    tick;
    chk1("basic_load_ir", instruction_reset, 1'b0);
    chk1("basic_load_ready", in_ready, 1'b1);
    chk1("basic_load_ws", write_signal, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_data = 32'(10 + i);
      tick;
      chk1("basic_ws", write_signal, 1'b1);
      chk("basic_addr", write_address, 32'(i));
      chk("basic_data", instruction_write, 32'(10 + i));
    end
    chk1("basic_drain_ready", in_ready, 1'b0);
    chk1("basic_drain_busy", busy, 1'b1);
    chk1("basic_drain_cpu_reset", cpu_reset, 1'b1);
    tick;
    in_valid = 1'b0;
    chk1("basic_run_ws", write_signal, 1'b0);
    chk1("basic_run_done", done, 1'b1);
    chk1("basic_run_cpu_reset", cpu_reset, 1'b0);
    chk("basic_run_sel_pc", 32'(select_pc), 32'd1);
    chk("basic_run_sel_ir2", 32'(select_ir2), 32'd0);
    chk1("basic_run_sel_pc2", select_pc2, 1'b0);
    chk1("basic_run_busy", busy, 1'b0);
    chk("basic_run_z4", z4, PC0);

    // illegal count while running keeps RUN
    start = 1'b1; word_count = 9'd0;
    tick;
    start = 1'b0;
    chk1("run_bad_error", error, 1'b1);
    chk1("run_bad_done", done, 1'b1);
    chk1("run_bad_ir", instruction_reset, 1'b0);

    // reload of two words from RUN
    start = 1'b1; word_count = 9'd2;
    tick;
    start = 1'b0;
    chk1("reload_cpu_reset", cpu_reset, 1'b1);
    chk1("reload_done", done, 1'b0);
    chk1("reload_ir", instruction_reset, 1'b1);
    chk1("reload_error", error, 1'b0);
    in_valid = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'hAAAA_0000 + 32'(i);
      tick;
      chk1("reload_ws", write_signal, 1'b1);
      chk("reload_addr", write_address, 32'(i));
      chk("reload_data", instruction_write, 32'hAAAA_0000 + 32'(i));
    end
    in_valid = 1'b0;
    tick;
    chk1("reload_run_done", done, 1'b1);
    chk1("reload_run_ws", write_signal, 1'b0);

    // stalled stream: valid pattern 1,0,0,1,0,1
    start = 1'b1; word_count = 9'd3;
    tick;
    start = 1'b0;
    tick;
    pat = 6'b101001;
    nws = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = pat[c];
      in_data  = 32'h50 + 32'(c);
      tick;
      chk1("stall_busy", busy, 1'b1);
      chk1("stall_ws", write_signal, pat[c]);
      if (write_signal) begin
        chk("stall_addr", write_address, 32'(nws));
        chk("stall_data", instruction_write, 32'h50 + 32'(c));
        nws++;
      end
    end
    in_valid = 1'b0;
    tick;
    chk("stall_nwrites", 32'(nws), 32'd3);
    chk1("stall_done", done, 1'b1);

    // reset in the middle of a five-word load
    start = 1'b1; word_count = 9'd5;
    tick;
    start = 1'b0;
    tick;
    in_valid = 1'b1; in_data = 32'd1;
    tick;
    in_data = 32'd2;
    tick;
    chk1("mid_ws", write_signal, 1'b1);
    chk("mid_addr", write_address, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick;
    chk1("midrst_hold_ws", write_signal, 1'b0);
    tick;
    reset = 1'b0;
    tick;
    chk1("post_rst_ws", write_signal, 1'b0);
    chk1("post_rst_ready", in_ready, 1'b0);
    chk1("post_rst_cpu_reset", cpu_reset, 1'b1);
    chk1("post_rst_busy", busy, 1'b0);
    in_valid = 1'b0;

    // illegal counts from IDLE, error sticky until a legal start
    start = 1'b1; word_count = 9'd0;
    tick;
    chk1("idle_zero_error", error, 1'b1);
    chk1("idle_zero_ir", instruction_reset, 1'b0);
    chk1("idle_zero_busy", busy, 1'b0);
    chk1("idle_zero_ws", write_signal, 1'b0);
    word_count = 9'd257;
    tick;
    start = 1'b0;
    chk1("idle_257_error", error, 1'b1);
    chk1("idle_257_busy", busy, 1'b0);
    chk1("idle_257_ir", instruction_reset, 1'b0);
    tick;
    chk1("idle_sticky_error", error, 1'b1);

    // full-depth load
    start = 1'b1; word_count = 9'd256;
    tick;
    start = 1'b0;
    chk1("full_error_clr", error, 1'b0);
    chk1("full_ir", instruction_reset, 1'b1);
    in_valid = 1'b1;
    tick;
    for (int i = 0; i < 256; i++) begin
      in_data = 32'hC000_0000 | 32'(i);
      tick;
      chk1("full_ws", write_signal, 1'b1);
      chk("full_addr", write_address, 32'(i));
      chk("full_data", instruction_write, 32'hC000_0000 | 32'(i));
    end
    in_valid = 1'b0;
    tick;
    chk1("full_done", done, 1'b1);
    chk1("full_run_ws", write_signal, 1'b0);
    chk("full_last_addr", write_address, 32'd255);
    chk1("full_cpu_reset", cpu_reset, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
